alu_arbiter: RTL

- Shares one combinational 32-bit ALU between two requesters (port 0, port 1) using valid/ready request and response channels.
- Arbitrates round-robin, registers the operands into the ALU and captures the result.
- Masks the ALU flags so that only the flags defined for the executed opcode are returned; all other flags read as 0.
- Sits between the issuing units and the ALU. It is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port valid/ready front end for one shared combinational ALU: operands registered, result and masked flags held.
// 3 cycles per op (IDLE grant, EXEC capture, RESP hold); requests stall while an op is in flight or its response is unconsumed.
module alu_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_aluc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_aluc,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_r,
  output logic [3:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_r,
  output logic [3:0]  rsp1_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        grant_id;
  logic        last_grant;
  logic        grant;
  logic        any_req;
  logic        carry_ok;
  logic        ovf_ok;
  logic [31:0] rsp_r;
  logic [3:0]  rsp_flags;

  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = RR_ENABLE ? ~last_grant : 1'b0;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) & req0_valid & ~grant;
  assign req1_ready = (state == IDLE) & req1_valid & grant;

  // The ALU leaves carry/overflow stale for opcodes that do not define them.
  assign carry_ok = alu_aluc inside {4'b0000, 4'b0001, 4'b1010, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
  assign ovf_ok   = alu_aluc inside {4'b0010, 4'b0011};

  assign rsp0_r     = rsp_r;
  assign rsp1_r     = rsp_r;
  assign rsp0_flags = rsp_flags;
  assign rsp1_flags = rsp_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_aluc   <= '0;
      rsp_r      <= '0;
      rsp_flags  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_a      <= grant ? req1_a    : req0_a;
            alu_b      <= grant ? req1_b    : req0_b;
            alu_aluc   <= grant ? req1_aluc : req0_aluc;
            grant_id   <= grant;
            last_grant <= grant;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_r      <= alu_r;
          rsp_flags  <= {alu_overflow & ovf_ok, alu_negative, alu_carry & carry_ok, alu_zero};
          rsp0_valid <= ~grant_id;
          rsp1_valid <= grant_id;
          state      <= RESP;
        end
        RESP: begin
          if (grant_id ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
